// File: rtl/spi_block_sequencer.sv
// Feeds a block to an SPI byte master one byte at a time and gathers the returned bytes.
// Optional per-byte watchdog enabled by defining SPI_SEQ_TIMEOUT_EN.
module spi_block_sequencer #(
   parameter int NUM_BYTES      = 16,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   blk_valid,
   output logic                   blk_ready,
   input  logic [8*NUM_BYTES-1:0] blk_data,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [8*NUM_BYTES-1:0] res_data,
   output logic                   res_err,
   output logic                   m_start,
   output logic [7:0]             m_data_in,
   input  logic                   m_busy,
   input  logic                   m_done,
   input  logic [7:0]             m_data_out
);
   localparam int DW = 8*NUM_BYTES;
   localparam int CW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [2:0] {IDLE, START, XFER, GAP, RESP} state_t;

   state_t        state;
   logic [DW-1:0] tx_shift;
   logic [DW-1:0] rx_shift;
   logic [DW-1:0] rx_next;
   logic [CW-1:0] byte_cnt;
   logic [GW-1:0] gap_cnt;

`ifdef SPI_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   // Holds the number of cycles elapsed since this byte's m_start.
   logic [TW-1:0] wd_cnt;
`else
   assign res_err = 1'b0;
`endif

   assign rx_next = {rx_shift[DW-9:0], m_data_out};

   // NOTE: all state and outputs here use non-blocking assignments so every
   // register samples the pre-edge values, whatever the statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         blk_ready <= 1'b1;
         res_valid <= 1'b0;
         res_data  <= '0;
         m_start   <= 1'b0;
         m_data_in <= '0;
         tx_shift  <= '0;
         rx_shift  <= '0;
         byte_cnt  <= '0;
         gap_cnt   <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
         res_err   <= 1'b0;
         wd_cnt    <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (blk_valid) begin
                  tx_shift  <= blk_data;
                  rx_shift  <= '0;
                  byte_cnt  <= '0;
                  m_data_in <= blk_data[DW-1 -: 8];
                  m_start   <= !m_busy;
                  blk_ready <= 1'b0;
                  state     <= START;
               end
            end
            START: begin
`ifdef SPI_SEQ_TIMEOUT_EN
               wd_cnt <= TW'(1);
`endif
               // m_start is already high for this cycle unless the master was busy.
               if (m_start) begin
                  m_start <= 1'b0;
                  state   <= XFER;
               end else if (!m_busy) begin
                  m_start <= 1'b1;
               end
            end
            XFER: begin
               if (m_done) begin
                  rx_shift  <= rx_next;
                  tx_shift  <= tx_shift << 8;
                  m_data_in <= tx_shift[DW-9 -: 8];
                  if (byte_cnt == CW'(NUM_BYTES - 1)) begin
                     res_valid <= 1'b1;
                     res_data  <= rx_next;
                     state     <= RESP;
                  end else begin
                     byte_cnt <= byte_cnt + CW'(1);
                     if (GAP_CYCLES == 0) begin
                        m_start <= !m_busy;
                        state   <= START;
                     end else begin
                        gap_cnt <= '0;
                        state   <= GAP;
                     end
                  end
               end
`ifdef SPI_SEQ_TIMEOUT_EN
               else if (wd_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  // Left-align the bytes received so far; missing bytes read as zero.
                  res_valid <= 1'b1;
                  res_err   <= 1'b1;
                  res_data  <= rx_shift << (8*(NUM_BYTES - int'(byte_cnt)));
                  state     <= RESP;
               end else begin
                  wd_cnt <= wd_cnt + TW'(1);
               end
`endif
            end
            GAP: begin
               if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                  m_start <= !m_busy;
                  state   <= START;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            RESP: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  blk_ready <= 1'b1;
                  state     <= IDLE;
`ifdef SPI_SEQ_TIMEOUT_EN
                  res_err   <= 1'b0;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
